sm_0535_path_map_tx: RTL
========================

// Module: sm_0535_path_map_tx
// PURPOSE
// Transmit-side peer of the bot's UART path receiver. Snapshots a 17-bit path-availability vector, frames it as
// a 6-byte message and feeds it one byte at a time to the UART transmitter using its tx_data_valid/tx_done handshake.
// Sits on the arena/host FPGA between path-map logic and the UART transmitter instance.
// PARAMETERS
// START_BYTE    8'h23  first byte of every frame ('#')
// END_BYTE      8'h0A  last byte of every frame ('\n')
// GAP_CYCLES    2      idle clocks after each tx_done before the next byte is offered (0 allowed)
// TIMEOUT_CYCLES 100000 clocks to wait for tx_done before the frame is aborted
// AUTO_SEND     1      1: a change of paths_in against the last value sent starts a frame automatically
// PORTS
// clk           in   1   system clock, all logic on rising edge
// rst           in   1   asynchronous, active-high reset
// paths_in      in   17  path availability, bit i = path i open
// send_req      in   1   single-cycle request to send the current paths_in
// tx_done       in   1   single-cycle pulse from the UART transmitter: byte fully shifted out
// tx_data_valid out  1   single-cycle strobe: tx_byte is ready for the transmitter
// tx_byte       out  8   byte to transmit, held stable from the strobe until tx_done
// busy          out  1   high from frame start until the frame completes or aborts
// frame_sent    out  1   single-cycle pulse: END_BYTE tx_done received
// tx_error      out  1   single-cycle pulse: timeout abort
// BEHAVIOUR
// - Reset (async): all outputs 0, state IDLE, pending=0, last_sent=17'h0, byte index 0, counters 0.
// - Frame, index 0..5: START_BYTE, b0=snap[7:0], b1=snap[15:8], b2={7'b0,snap[16]}, chk=b0^b1^b2, END_BYTE.
// - snap is latched on leaving IDLE. Later paths_in changes never alter the frame in flight.
// - States: IDLE -> SEND -> WAIT_DONE -> GAP -> SEND ... -> IDLE.
//   IDLE: trigger = send_req | pending | (AUTO_SEND & paths_in!=last_sent). On trigger: latch snap, clear pending,
//         busy=1, idx=0, go to SEND.
//   SEND: drive tx_byte=frame[idx] and tx_data_valid=1 for exactly one cycle. Go to WAIT_DONE. Clear the timeout counter.
//   WAIT_DONE: tx_byte held. On tx_done: if idx==5, pulse frame_sent, set last_sent=snap and busy=0, go to IDLE.
//         Otherwise idx++ and go to GAP (or straight to SEND when GAP_CYCLES==0).
//         If the counter reaches TIMEOUT_CYCLES without tx_done: pulse tx_error, busy=0, go to IDLE.
//         last_sent is not updated on abort, so AUTO_SEND retries.
//   GAP: count GAP_CYCLES clocks, then go to SEND.
// - Latency: send_req sampled high in IDLE at edge N gives tx_data_valid high in the cycle after edge N+1.
// - tx_done outside WAIT_DONE is ignored. A tx_done in the same cycle as the timeout terminal count counts as done.
// - send_req while busy sets pending. Exactly one extra frame follows, with a fresh snapshot; multiple requests collapse.
// - send_req and the AUTO_SEND condition together start one frame only.
// - frame_sent and tx_error are mutually exclusive and each lasts one cycle.
// - rst mid-frame: immediate return to reset values. No partial byte is re-offered, pending is lost.
// TESTING
// 1 paths_in=17'h1A5C3, send_req pulse, tx_done 20 clks after each strobe -> tx_byte 23,C3,A5,01,67,0A;
//   6 strobes each GAP_CYCLES+1 clks after the previous tx_done; frame_sent once; busy low after.
// 2 AUTO_SEND=1, paths_in 0 -> 17'h00001 -> frame 23,01,00,00,01,0A; no further frame while paths_in is steady.
// 3 paths_in changed to 17'h10000 during byte 2 -> current frame keeps old data; next frame 23,00,00,01,01,0A.
// 4 send_req pulsed 3x while busy -> exactly one extra frame after frame_sent, not three.
// 5 TIMEOUT_CYCLES=50, tx_done withheld -> tx_error pulse 50 clks after the strobe, busy=0, no frame_sent.
// 6 rst asserted in WAIT_DONE of byte 3 -> outputs 0 asynchronously; after release, idle until the next trigger.

Source files
------------

// File: rtl/sm_0535_path_map_tx.sv
// Frames a 17-bit path-availability map as a 6-byte UART message and paces it
// through the transmitter's tx_data_valid/tx_done handshake with gap and timeout control.
module sm_0535_path_map_tx #(
  parameter logic [7:0] START_BYTE     = 8'h23,
  parameter logic [7:0] END_BYTE       = 8'h0A,
  parameter int         GAP_CYCLES     = 2,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter bit         AUTO_SEND      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [16:0] paths_in,
  input  logic        send_req,
  input  logic        tx_done,
  output logic        tx_data_valid,
  output logic [7:0]  tx_byte,
  output logic        busy,
  output logic        frame_sent,
  output logic        tx_error
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  // One counter serves both the gap and the timeout, so it is sized for the larger.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [2:0]    LAST_IDX = 3'd5;

  function automatic logic [7:0] check_byte(input logic [16:0] snap);
    check_byte = snap[7:0] ^ snap[15:8] ^ {7'b0000000, snap[16]};
  endfunction

  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [16:0] snap);
    case (idx)
      3'd0:    frame_byte = START_BYTE;
      3'd1:    frame_byte = snap[7:0];
      3'd2:    frame_byte = snap[15:8];
      3'd3:    frame_byte = {7'b0000000, snap[16]};
      3'd4:    frame_byte = check_byte(snap);
      3'd5:    frame_byte = END_BYTE;
      default: frame_byte = 8'h00;
    endcase
  endfunction

  state_t         state_r, state_s;
  logic [16:0]    snap_r, snap_s;
  logic [16:0]    last_sent_r, last_sent_s;
  logic           pending_r, pending_s;
  logic [2:0]     idx_r, idx_s;
  logic [CW-1:0]  cnt_r, cnt_s;
  logic           valid_s, busy_s, sent_s, error_s;
  logic [7:0]     byte_s;
  logic           trigger_s;

  assign trigger_s = send_req | pending_r | (AUTO_SEND & (paths_in != last_sent_r));

  // Next-state and next-output logic for the framing FSM.
  always_comb begin
    state_s     = state_r;
    snap_s      = snap_r;
    last_sent_s = last_sent_r;
    pending_s   = pending_r;
    idx_s       = idx_r;
    cnt_s       = cnt_r;
    valid_s     = 1'b0;
    byte_s      = tx_byte;
    busy_s      = busy;
    sent_s      = 1'b0;
    error_s     = 1'b0;
    if (busy && send_req) begin
      pending_s = 1'b1;
    end else begin
      pending_s = pending_r;
    end
    case (state_r)
      IDLE: begin
        if (trigger_s) begin
          state_s   = SEND;
          snap_s    = paths_in;
          pending_s = 1'b0;
          busy_s    = 1'b1;
          idx_s     = 3'd0;
        end else begin
          busy_s = 1'b0;
        end
      end
      SEND: begin
        valid_s = 1'b1;
        byte_s  = frame_byte(idx_r, snap_r);
        cnt_s   = {CW{1'b0}};
        state_s = WAIT_DONE;
      end
      WAIT_DONE: begin
        // tx_done wins over a coincident timeout terminal count.
        if (tx_done) begin
          if (idx_r == LAST_IDX) begin
            state_s     = IDLE;
            sent_s      = 1'b1;
            busy_s      = 1'b0;
            last_sent_s = snap_r;
          end else begin
            idx_s = idx_r + 3'd1;
            cnt_s = {CW{1'b0}};
            if (GAP_CYCLES == 0) begin
              state_s = SEND;
            end else begin
              state_s = GAP;
            end
          end
        end else if (cnt_r == TO_LAST) begin
          state_s = IDLE;
          error_s = 1'b1;
          busy_s  = 1'b0;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      GAP: begin
        if (cnt_r == GAP_LAST) begin
          state_s = SEND;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      snap_r        <= 17'h00000;
      last_sent_r   <= 17'h00000;
      pending_r     <= 1'b0;
      idx_r         <= 3'd0;
      cnt_r         <= {CW{1'b0}};
      tx_data_valid <= 1'b0;
      tx_byte       <= 8'h00;
      busy          <= 1'b0;
      frame_sent    <= 1'b0;
      tx_error      <= 1'b0;
    end else begin
      state_r       <= state_s;
      snap_r        <= snap_s;
      last_sent_r   <= last_sent_s;
      pending_r     <= pending_s;
      idx_r         <= idx_s;
      cnt_r         <= cnt_s;
      tx_data_valid <= valid_s;
      tx_byte       <= byte_s;
      busy          <= busy_s;
      frame_sent    <= sent_s;
      tx_error      <= error_s;
    end
  end

endmodule
